// File: rtl/sic_alu_lock_arbiter.sv
// sic_alu_lock_arbiter: oldest-first request/grant/release lock sharing one ALU among NUM_SIC units.
// Optional owner-idle watchdog enabled by defining SIC_ALU_ARB_WATCHDOG_EN.
module sic_alu_lock_arbiter #(
  parameter int NUM_SIC     = 4,
  parameter int ID_WIDTH    = 8,
  parameter int OP_W        = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SIC-1:0]           req,
  input  logic [NUM_SIC*ID_WIDTH-1:0]  req_issue_id,
  input  logic [NUM_SIC-1:0]           release_lock,
  input  logic [NUM_SIC*OP_W-1:0]      in_op,
  input  logic [NUM_SIC*32-1:0]        in_a,
  input  logic [NUM_SIC*32-1:0]        in_b,
  output logic [NUM_SIC-1:0]           grant,
  output logic [OP_W-1:0]              alu_op,
  output logic [31:0]                  alu_a,
  output logic [31:0]                  alu_b,
  output logic                         lock_busy,
  output logic                         protocol_err
);
  localparam int OW = $clog2(NUM_SIC);
  localparam logic [NUM_SIC-1:0] ONE = 1;
  typedef enum logic {FREE, HELD} state_t;
  state_t state, state_n;
  logic [OW-1:0] owner, owner_n, win;
  logic found, own_rel, bad_rel, wdog_fire;
  logic [ID_WIDTH-1:0] best_id, diff;
  // Ascending scan with strict "older" keeps the lower index on equal ids.
  always_comb begin
    win = '0;
    found = 1'b0;
    best_id = '0;
    diff = '0;
    for (int i = 0; i < NUM_SIC; i++) begin
      diff = req_issue_id[i*ID_WIDTH +: ID_WIDTH] - best_id;
      if (req[i] && (!found || diff[ID_WIDTH-1])) begin
        found = 1'b1;
        win = OW'(i);
        best_id = req_issue_id[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end
  assign lock_busy = state == HELD;
  assign own_rel = lock_busy && release_lock[owner];
  assign bad_rel = lock_busy ? |(release_lock & ~(ONE << owner)) : |release_lock;
  assign alu_op = lock_busy ? in_op[owner*OP_W +: OP_W] : '0;
  assign alu_a = lock_busy ? in_a[owner*32 +: 32] : '0;
  assign alu_b = lock_busy ? in_b[owner*32 +: 32] : '0;
`ifdef SIC_ALU_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES) + 1;
  logic [CW-1:0] wdog;
  logic idle;
  assign idle = lock_busy && !req[owner] && !release_lock[owner];
  assign wdog_fire = idle && wdog == CW'(WDOG_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdog <= '0;
    else if (!lock_busy || req[owner]) wdog <= '0;
    else if (idle) wdog <= wdog + 1'b1;
`else
  assign wdog_fire = WDOG_CYCLES < 0;
`endif
  always_comb begin
    state_n = state;
    owner_n = owner;
    if (state == FREE && found) begin
      state_n = HELD;
      owner_n = win;
    end else if (own_rel || wdog_fire) begin
      state_n = FREE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FREE;
      owner <= '0;
      grant <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      grant <= state_n == HELD ? ONE << owner_n : '0;
      protocol_err <= protocol_err | bad_rel | wdog_fire;
    end
endmodule

// File: tb/tb_sic_alu_lock_arbiter.sv
// tb_sic_alu_lock_arbiter: directed tests for the ALU lock arbiter (watchdog path under SIC_ALU_ARB_WATCHDOG_EN).
module tb_sic_alu_lock_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] req_issue_id = '0;
  logic [3:0] release_lock = '0;
  logic [15:0] in_op = '0;
  logic [127:0] in_a = '0;
  logic [127:0] in_b = '0;
  logic [3:0] grant;
  logic [3:0] alu_op;
  logic [31:0] alu_a, alu_b;
  logic lock_busy, protocol_err;
  int checks = 0;
  int errors = 0;

  sic_alu_lock_arbiter #(.NUM_SIC(4), .ID_WIDTH(8), .OP_W(4), .WDOG_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_issue_id(req_issue_id),
    .release_lock(release_lock), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .grant(grant), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .lock_busy(lock_busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = '0;
    release_lock = '0;
    req_issue_id = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_id(input int u, input logic [7:0] v);
    req_issue_id[u*8 +: 8] = v;
  endtask

  task automatic test_reset;
    in_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    do_reset();
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b exp 0000", grant); end
    checks++; if (lock_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", lock_busy); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", protocol_err); end
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL reset_alu_a: got %h exp 0", alu_a); end
  endtask

  task automatic test_single;
    do_reset();
    in_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'hDEADBEEF};
    in_b = {32'h88888888, 32'h77777777, 32'h66666666, 32'h12345678};
    in_op = 16'h765A;
    req = 4'b0001;
    set_id(0, 8'd5);
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b exp 0001", grant); end
    checks++; if (lock_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", lock_busy); end
    checks++; if (alu_a !== 32'hDEADBEEF) begin errors++; $display("FAIL single_alu_a: got %h exp deadbeef", alu_a); end
    checks++; if (alu_b !== 32'h12345678) begin errors++; $display("FAIL single_alu_b: got %h exp 12345678", alu_b); end
    checks++; if (alu_op !== 4'hA) begin errors++; $display("FAIL single_alu_op: got %h exp a", alu_op); end
    req = 4'b0000;
    tick();
    release_lock = 4'b0001;
    tick();
    release_lock = 4'b0000;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release_grant: got %b exp 0000", grant); end
    checks++; if (lock_busy !== 1'b0) begin errors++; $display("FAIL single_release_busy: got %b exp 0", lock_busy); end
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL single_free_alu_a: got %h exp 0", alu_a); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b exp 0", protocol_err); end
  endtask

  task automatic test_age_wrap;
    do_reset();
    req = 4'b0110;
    set_id(1, 8'hFE);
    set_id(2, 8'h01);
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wrap_grant: got %b exp 0010", grant); end
    checks++; if (alu_a !== 32'h22222222) begin errors++; $display("FAIL wrap_alu_a: got %h exp 22222222", alu_a); end
    req = 4'b0100;
    release_lock = 4'b0010;
    tick();
    release_lock = 4'b0000;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wrap_free_gap: got %b exp 0000", grant); end
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL wrap_regrant: got %b exp 0100", grant); end
  endtask

  task automatic test_tie_contention;
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int u = 0; u < 4; u++) set_id(u, 8'd7);
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL tie_grant: got %b exp 0001", grant); end
    repeat (3) tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL tie_hold: got %b exp 0001", grant); end
    for (int u = 0; u < 4; u++) begin
      req[u] = 1'b0;
      release_lock = 4'b0001 << u;
      tick();
      release_lock = 4'b0000;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL tie_gap%0d: got %b exp 0000", u, grant); end
      tick();
      exp = (u < 3) ? (4'b0010 << u) : 4'b0000;
      checks++; if (grant !== exp) begin errors++; $display("FAIL tie_next%0d: got %b exp %b", u, grant, exp); end
    end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL tie_err: got %b exp 0", protocol_err); end
  endtask

  task automatic test_protocol_err;
    do_reset();
    req = 4'b0001;
    tick();
    release_lock = 4'b0100;
    tick();
    release_lock = 4'b0000;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL perr_nonowner_grant: got %b exp 0001", grant); end
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_nonowner_err: got %b exp 1", protocol_err); end
    tick();
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b exp 1", protocol_err); end
    do_reset();
    release_lock = 4'b0001;
    tick();
    release_lock = 4'b0000;
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_free_release: got %b exp 1", protocol_err); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL perr_free_grant: got %b exp 0000", grant); end
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    release_lock = 4'b0011;
    tick();
    release_lock = 4'b0000;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL perr_multi_grant: got %b exp 0000", grant); end
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_multi_err: got %b exp 1", protocol_err); end
  endtask

  task automatic test_abort;
    do_reset();
    req = 4'b0100;
    set_id(2, 8'd3);
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL abort_owner: got %b exp 0100", grant); end
    req = 4'b1101;
    set_id(0, 8'd9);
    set_id(3, 8'd1);
    repeat (2) tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL abort_pending_hold: got %b exp 0100", grant); end
    req = 4'b0001;
    tick();
    release_lock = 4'b0100;
    tick();
    release_lock = 4'b0000;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL abort_free: got %b exp 0000", grant); end
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL abort_regrant: got %b exp 0001", grant); end
    checks++; if (alu_a !== 32'hDEADBEEF) begin errors++; $display("FAIL abort_alu_a: got %h exp deadbeef", alu_a); end
  endtask

  task automatic test_reset_midlock;
    do_reset();
    req = 4'b0010;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midlock_grant: got %b exp 0000", grant); end
    checks++; if (lock_busy !== 1'b0) begin errors++; $display("FAIL midlock_busy: got %b exp 0", lock_busy); end
    req = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_watchdog;
    do_reset();
    req = 4'b0001;
    repeat (6) tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wdog_req_high: got %b exp 0001", grant); end
    req = 4'b0000;
`ifdef SIC_ALU_ARB_WATCHDOG_EN
    repeat (3) tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wdog_early: got %b exp 0001", grant); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL wdog_early_err: got %b exp 0", protocol_err); end
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wdog_fire: got %b exp 0000", grant); end
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL wdog_err: got %b exp 1", protocol_err); end
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL nowdog_hold%0d: got %b exp 0001", c, grant); end
    end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL nowdog_err: got %b exp 0", protocol_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_age_wrap();
    test_tie_contention();
    test_protocol_err();
    test_abort();
    test_reset_midlock();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
